// File: rtl/divider_job_feeder_if.sv
// Job, divider and result handshake bundle for divider_job_feeder.
// The master modport is the feeder; the slave modport is its environment.
interface divider_job_feeder_if;
    logic [3:0] in_x;
    logic [3:0] in_y;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] div_xin;
    logic [3:0] div_yin;
    logic       div_start;
    logic       div_ack;
    logic       div_done;
    logic [3:0] div_quotient;
    logic [3:0] div_remainder;
    logic       res_valid;
    logic [3:0] res_q;
    logic [3:0] res_r;
    logic       res_divzero;
    logic       res_taken;

    modport master (
        input  in_x, in_y, in_valid, div_done, div_quotient, div_remainder, res_taken,
        output in_ready, div_xin, div_yin, div_start, div_ack,
        output res_valid, res_q, res_r, res_divzero
    );

    modport slave (
        output in_x, in_y, in_valid, div_done, div_quotient, div_remainder, res_taken,
        input  in_ready, div_xin, div_yin, div_start, div_ack,
        input  res_valid, res_q, res_r, res_divzero
    );
endinterface

// File: rtl/divider_job_feeder.sv
// Queues operand pairs, issues them one at a time to a 4-bit iterative divider,
// short-circuits divide-by-zero and holds each result for the consumer.
module divider_job_feeder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    divider_job_feeder_if.master bus,
    output logic [ADDR_W:0]     o_count,
    output logic                o_busy
);
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_WAIT  = 4'b0100,
        S_ACK   = 4'b1000
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_mem_x [DEPTH];
    logic [3:0]        r_mem_y [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_res_valid;
    logic [3:0]        r_res_q;
    logic [3:0]        r_res_r;
    logic              r_res_divzero;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [3:0]        w_head_x;
    logic [3:0]        w_head_y;
    logic              w_load;
    logic [3:0]        w_load_q;
    logic [3:0]        w_load_r;
    logic              w_load_divzero;

    assign w_full   = (r_count == (ADDR_W+1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = bus.in_valid & ~w_full;
    assign w_head_x = r_mem_x[r_rd_ptr];
    assign w_head_y = r_mem_y[r_rd_ptr];

    // Storage carries no reset: only entries between the pointers are ever read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_x[r_wr_ptr] <= bus.in_x;
            r_mem_y[r_wr_ptr] <= bus.in_y;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        w_pop          = 1'b0;
        w_load         = 1'b0;
        w_load_q       = '0;
        w_load_r       = '0;
        w_load_divzero = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !r_res_valid) begin
                    // Y=0 would hang the divider, so it is answered here instead.
                    if (w_head_y == 4'd0) begin
                        w_load         = 1'b1;
                        w_load_q       = 4'hF;
                        w_load_r       = w_head_x;
                        w_load_divzero = 1'b1;
                        w_pop          = 1'b1;
                    end else begin
                        w_state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT: begin
                // With the result register occupied the divider parks in done.
                if (bus.div_done && !r_res_valid && !w_empty) begin
                    w_load       = 1'b1;
                    w_load_q     = bus.div_quotient;
                    w_load_r     = bus.div_remainder;
                    w_pop        = 1'b1;
                    w_state_next = S_ACK;
                end
            end
            S_ACK:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_res_valid   <= 1'b0;
            r_res_q       <= '0;
            r_res_r       <= '0;
            r_res_divzero <= 1'b0;
        end else if (w_load) begin
            r_res_valid   <= 1'b1;
            r_res_q       <= w_load_q;
            r_res_r       <= w_load_r;
            r_res_divzero <= w_load_divzero;
        end else if (r_res_valid && bus.res_taken) begin
            r_res_valid <= 1'b0;
        end
    end

    assign bus.in_ready    = ~w_full;
    assign bus.div_xin     = w_head_x;
    assign bus.div_yin     = w_head_y;
    assign bus.div_start   = (r_state == S_ISSUE);
    assign bus.div_ack     = (r_state == S_ACK);
    assign bus.res_valid   = r_res_valid;
    assign bus.res_q       = r_res_q;
    assign bus.res_r       = r_res_r;
    assign bus.res_divzero = r_res_divzero;
    assign o_count         = r_count;
    assign o_busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_divider_job_feeder.sv
// Bench for divider_job_feeder with a behavioural iterative divider attached,
// a queue-based job/result model and directed scenarios.
module tb_divider_job_feeder;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] count;
    logic       busy;

    divider_job_feeder_if bus ();

    divider_job_feeder #(.DEPTH(DEPTH), .ADDR_W(2)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .bus    (bus.master),
        .o_count(count),
        .o_busy (busy)
    );

    always #5 clk = ~clk;

    // Behavioural 4-bit repeated-subtraction divider: init -> compute -> done -> (ack) init.
    logic [1:0] d_state;
    logic [3:0] d_x, d_y, d_q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d_state <= 2'd0; d_x <= 4'd0; d_y <= 4'd0; d_q <= 4'd0;
        end else begin
            case (d_state)
                2'd0: if (bus.div_start) begin
                    d_x <= bus.div_xin; d_y <= bus.div_yin; d_q <= 4'd0; d_state <= 2'd1;
                end
                2'd1: if (d_x >= d_y) begin
                    d_x <= d_x - d_y; d_q <= d_q + 4'd1;
                end else d_state <= 2'd2;
                default: if (bus.div_ack) d_state <= 2'd0;
            endcase
        end
    end
    assign bus.div_done      = (d_state == 2'd2);
    assign bus.div_quotient  = d_q;
    assign bus.div_remainder = d_x;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Model state: jobs accepted but not yet popped, and the log of delivered results.
    logic [7:0] jobs[$];
    logic [8:0] log_q[$];
    int  m_count = 0;
    int  start_cnt = 0, ack_cnt = 0;
    int  start_x = 0, start_y = 0;
    logic prev_valid = 0, prev_start = 0, prev_ack = 0, expect_clear = 0;
    logic [3:0] last_q = 0, last_r = 0;
    logic last_dz = 0;

    always @(posedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) begin
            jobs.push_back({bus.in_x, bus.in_y});
            m_count++;
            $display("PUSH x=%0d y=%0d", bus.in_x, bus.in_y);
        end
    end

    always @(negedge clk) begin
        logic [7:0] j;
        int eq, er, edz;
        if (rst) begin
            jobs.delete();
            m_count = 0; prev_valid = 0; prev_start = 0; prev_ack = 0; expect_clear = 0;
            last_q = 0; last_r = 0; last_dz = 0;
            chk("rst_in_ready", bus.in_ready, 1);
            chk("rst_count", count, 0);
            chk("rst_res_valid", bus.res_valid, 0);
            chk("rst_start", bus.div_start, 0);
            chk("rst_ack", bus.div_ack, 0);
            chk("rst_busy", busy, 0);
        end else begin
            if (expect_clear) chk("taken_clears_valid", bus.res_valid, 0);
            if (bus.res_valid && !prev_valid) begin
                if (jobs.size() == 0) fail_now("result_without_job");
                else begin
                    j = jobs.pop_front();
                    m_count--;
                    edz = (j[3:0] == 4'd0) ? 1 : 0;
                    eq  = edz ? 15 : int'(j[7:4]) / int'(j[3:0]);
                    er  = edz ? int'(j[7:4]) : int'(j[7:4]) % int'(j[3:0]);
                    chk("res_q", bus.res_q, eq);
                    chk("res_r", bus.res_r, er);
                    chk("res_divzero", bus.res_divzero, edz);
                    last_q = 4'(eq); last_r = 4'(er); last_dz = 1'(edz);
                    log_q.push_back({bus.res_divzero, bus.res_q, bus.res_r});
                    $display("RESULT x=%0d y=%0d q=%0d r=%0d dz=%0d", j[7:4], j[3:0],
                             bus.res_q, bus.res_r, bus.res_divzero);
                end
            end else begin
                chk("res_q_hold", bus.res_q, last_q);
                chk("res_r_hold", bus.res_r, last_r);
                chk("res_dz_hold", bus.res_divzero, last_dz);
            end
            chk("count", count, m_count);
            chk("in_ready", bus.in_ready, (m_count != DEPTH) ? 1 : 0);
            if (m_count != 0) begin
                chk("head_x", bus.div_xin, jobs[0][7:4]);
                chk("head_y", bus.div_yin, jobs[0][3:0]);
            end
            chk("start_one_cycle", prev_start & bus.div_start, 0);
            chk("ack_one_cycle", prev_ack & bus.div_ack, 0);
            chk("start_while_done", bus.div_start & bus.div_done, 0);
            if (bus.div_start) begin
                chk("start_y_nonzero", (bus.div_yin != 0) ? 1 : 0, 1);
                start_cnt++; start_x = bus.div_xin; start_y = bus.div_yin;
            end
            if (bus.div_ack) ack_cnt++;
            expect_clear = bus.res_valid & bus.res_taken;
            prev_valid = bus.res_valid;
            prev_start = bus.div_start;
            prev_ack   = bus.div_ack;
        end
    end

    task automatic push(input int x, input int y);
        int k;
        bus.in_x = 4'(x); bus.in_y = 4'(y); bus.in_valid = 1'b1;
        k = 0;
        while (k < 300) begin
            @(negedge clk);
            if (bus.in_ready) break;
            k++;
        end
        if (k >= 300) fail_now("push_timeout");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_log(input int n);
        int k;
        k = 0;
        while (log_q.size() < n && k < 500) begin
            @(posedge clk); k++;
        end
        if (log_q.size() < n) fail_now("result_timeout");
        #1;
    endtask

    task automatic chk_log(input int idx, input int q, input int r, input int dz);
        if (idx >= log_q.size()) fail_now("log_missing");
        else begin
            chk("log_q", log_q[idx][7:4], q);
            chk("log_r", log_q[idx][3:0], r);
            chk("log_dz", log_q[idx][8], dz);
        end
    endtask

    int base;
    int k;
    int exp_tab [5][2] = '{'{15, 0}, '{3, 1}, '{1, 0}, '{0, 2}, '{2, 2}};

    initial begin
        bus.in_x = 0; bus.in_y = 0; bus.in_valid = 0; bus.res_taken = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("init_in_ready", bus.in_ready, 1);
        chk("init_count", count, 0);
        chk("init_busy", busy, 0);

        // Normal job through the divider.
        push(13, 3);
        wait_log(1);
        repeat (4) @(posedge clk); #1;
        chk_log(0, 4, 1, 0);
        chk("t2_start_cnt", start_cnt, 1);
        chk("t2_ack_cnt", ack_cnt, 1);
        chk("t2_start_x", start_x, 13);
        chk("t2_start_y", start_y, 3);
        chk("t2_count", count, 0);

        // Divide-by-zero never reaches the divider.
        push(9, 0);
        wait_log(2);
        repeat (3) @(posedge clk); #1;
        chk_log(1, 15, 9, 1);
        chk("t3_start_cnt", start_cnt, 1);
        chk("t3_count", count, 0);

        // Backpressure: fill the FIFO while results are not taken.
        bus.res_taken = 0;
        push(15, 1); push(7, 2); push(6, 6); push(2, 5);
        chk("t4_full_count", count, 4);
        chk("t4_full_ready", bus.in_ready, 0);
        push(8, 3);
        wait_log(3);
        repeat (10) @(posedge clk); #1;
        chk("t4_stall_valid", bus.res_valid, 1);
        chk("t4_stall_starts", start_cnt, 2);
        chk("t4_stall_acks", ack_cnt, 2);
        chk("t4_stall_count", count, 4);
        bus.res_taken = 1;
        wait_log(7);
        for (int i = 0; i < 5; i++) chk_log(2 + i, exp_tab[i][0], exp_tab[i][1], 0);
        repeat (3) @(posedge clk); #1;

        // Reset in the middle of a divide.
        base = start_cnt;
        push(14, 2);
        k = 0;
        while (start_cnt == base && k < 50) begin @(posedge clk); k++; end
        if (start_cnt == base) fail_now("t5_no_start");
        @(posedge clk); #1;
        chk("t5_busy_before_reset", busy, 1);
        base = log_q.size();
        rst = 1; #1;
        chk("t5_rst_ready", bus.in_ready, 1);
        chk("t5_rst_count", count, 0);
        chk("t5_rst_valid", bus.res_valid, 0);
        chk("t5_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("t5_no_stale_result", log_q.size(), base);
        push(5, 5);
        wait_log(base + 1);
        chk_log(base, 1, 0, 0);
        repeat (4) @(posedge clk); #1;

        // Push on the same edge the head pops.
        base = log_q.size();
        push(15, 1);
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            if (bus.div_done) break;
            k++;
        end
        if (k >= 100) fail_now("t6_no_done");
        #1;
        bus.in_x = 4'd3; bus.in_y = 4'd2; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("t6_count_same_edge", count, 1);
        wait_log(base + 2);
        chk_log(base, 15, 0, 0);
        chk_log(base + 1, 1, 1, 0);
        repeat (4) @(posedge clk); #1;
        chk("t6_final_count", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
